// File: rtl/rf_port_driver_pkg.sv
// Shared definitions for the register file port driver: default widths,
// command op encoding and the FSM state type.
package rf_port_driver_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_VERIFY = 3'd2,
    ST_READ   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/rf_port_driver_errcnt.sv
// 8-bit saturating counter of write readback mismatches.
// Only instantiated when RF_PORT_DRIVER_VERIFY_EN is defined.
module rf_port_driver_errcnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] count
);

  // Count mismatch pulses and stick at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/rf_port_driver.sv
// Register file port driver: turns single-word read/write commands into
// register file write-port / read-port-1 accesses and returns one response
// per command. Defining RF_PORT_DRIVER_VERIFY_EN adds a readback check of
// every write (VERIFY state, rsp_err, err_cnt).
module rf_port_driver
  import rf_port_driver_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr1,
  input  logic [DATA_W-1:0] rf_rdata1,
`ifdef RF_PORT_DRIVER_VERIFY_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              busy
);

  state_t            state;
  logic [DATA_W-1:0] data_q;

`ifdef RF_PORT_DRIVER_VERIFY_EN
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] expected;
  logic              mismatch;

  // A hardwired zero register never stores the written value.
  assign expected = (ZERO_REG && (addr_q == '0)) ? '0 : data_q;
  assign mismatch = (rf_rdata1 != expected);

  rf_port_driver_errcnt u_errcnt (
    .clk   (clk),
    .rst   (rst),
    .inc   ((state == ST_VERIFY) && mismatch),
    .count (err_cnt)
  );

  // Keep the target address for the readback cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if ((state == ST_IDLE) && cmd_valid) begin
      addr_q <= cmd_addr;
    end
  end
`else
  // ZERO_REG only influences the readback expectation.
  logic unused_cfg;
  assign unused_cfg = ZERO_REG;
`endif

  // Main FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rf_wen    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      rf_raddr1 <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            data_q    <= cmd_wdata;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_write == OP_WRITE) begin
              state    <= ST_WRITE;
              rf_wen   <= 1'b1;
              rf_waddr <= cmd_addr;
              rf_wdata <= cmd_wdata;
            end else begin
              state     <= ST_READ;
              rf_raddr1 <= cmd_addr;
            end
          end
        end
        ST_WRITE: begin
          rf_wen <= 1'b0;
`ifdef RF_PORT_DRIVER_VERIFY_EN
          state     <= ST_VERIFY;
          rf_raddr1 <= addr_q;
`else
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= data_q;
          rsp_err   <= 1'b0;
`endif
        end
`ifdef RF_PORT_DRIVER_VERIFY_EN
        ST_VERIFY: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= rf_rdata1;
          rsp_err   <= mismatch;
        end
`endif
        ST_READ: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= rf_rdata1;
          rsp_err   <= 1'b0;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          rf_wen    <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_port_driver.sv
// Testbench for rf_port_driver with a behavioural register file attached.
// Works with or without RF_PORT_DRIVER_VERIFY_EN defined.
module tb_rf_port_driver;

  localparam bit ZERO_REG = 1'b1;
`ifdef RF_PORT_DRIVER_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr1;
  logic [31:0] rf_rdata1;
  logic        busy;
`ifdef RF_PORT_DRIVER_VERIFY_EN
  logic [7:0]  err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Register file stand-in and the bench's own view of its contents.
  logic [31:0] mem [32];
  logic [31:0] shadow [32];
  logic        corrupt = 1'b0;
  int          exp_errs = 0;

  rf_port_driver #(.ADDR_W(5), .DATA_W(32), .ZERO_REG(ZERO_REG)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_raddr1 (rf_raddr1),
    .rf_rdata1 (rf_rdata1),
`ifdef RF_PORT_DRIVER_VERIFY_EN
    .err_cnt   (err_cnt),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_wen) mem[rf_waddr] <= rf_wdata;
  end

  assign rf_rdata1 = corrupt ? 32'h0 :
                     ((ZERO_REG && rf_raddr1 == 5'd0) ? 32'h0 : mem[rf_raddr1]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_data"},  rsp_data, 32'd0);
    check({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
    check({tag, "_rf_wen"},    {31'd0, rf_wen}, 32'd0);
    check({tag, "_rf_waddr"},  {27'd0, rf_waddr}, 32'd0);
    check({tag, "_rf_wdata"},  rf_wdata, 32'd0);
    check({tag, "_rf_raddr1"}, {27'd0, rf_raddr1}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy}, 32'd0);
  endtask

  // Value a register reads back once d has been written to a.
  function automatic logic [31:0] stored(input logic [4:0] a, input logic [31:0] d);
    return (ZERO_REG && a == 5'd0) ? 32'h0 : d;
  endfunction

  // Issue one command, wait for its response while holding rsp_ready low for
  // 'hold' cycles, and compare everything against the bench model.
  task automatic do_cmd(input logic wr, input logic [4:0] a, input logic [31:0] d,
                        input int hold, input logic bad);
    int n;
    int wen_cnt;
    int lat;
    bit seen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;

    if (wr) begin
      exp_data = VERIFY_ON ? (bad ? 32'h0 : stored(a, d)) : d;
      exp_err  = VERIFY_ON && bad && (stored(a, d) != 32'h0);
      exp_lat  = VERIFY_ON ? 3 : 2;
    end else begin
      exp_data = (ZERO_REG && a == 5'd0) ? 32'h0 : shadow[a];
      exp_err  = 1'b0;
      exp_lat  = 2;
    end

    corrupt   = bad;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    rsp_ready = (hold == 0);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_addr  = 5'($urandom);
    cmd_wdata = $urandom;
    check("busy_active", {31'd0, busy}, 32'd1);
    check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    ra = rf_raddr1;
    wen_cnt = 0; wa = 5'd0; wd = 32'd0; seen = 1'b0; lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (rf_wen) begin
        wen_cnt++;
        wa = rf_waddr;
        wd = rf_wdata;
      end
      if (rsp_valid) begin
        seen = 1'b1;
        lat = i + 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("rsp_valid_seen", {31'd0, seen}, 32'd1);
    check("rsp_latency", lat, exp_lat);
    if (wr) begin
      check("wen_cycles", wen_cnt, 32'd1);
      check("rf_waddr", {27'd0, wa}, {27'd0, a});
      check("rf_wdata", wd, d);
      if (!(ZERO_REG && a == 5'd0)) shadow[a] = d;
    end else begin
      check("wen_cycles_read", wen_cnt, 32'd0);
      check("rf_raddr1", {27'd0, ra}, {27'd0, a});
    end
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_data", rsp_data, exp_data);
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    corrupt   = 1'b0;
    check("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
    check("cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
    if (exp_err && exp_errs < 255) exp_errs++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]    = 32'h0;
      shadow[i] = 32'h0;
    end
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 5'd0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");
`ifdef RF_PORT_DRIVER_VERIFY_EN
    check("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif

    // Directed write then read of register 5.
    do_cmd(1'b1, 5'd5, 32'h3F, 0, 1'b0);
    do_cmd(1'b0, 5'd5, 32'h0, 0, 1'b0);

    // Write to the hardwired zero register.
    do_cmd(1'b1, 5'd0, 32'hDEADBEEF, 0, 1'b0);
`ifdef RF_PORT_DRIVER_VERIFY_EN
    check("err_cnt_zero_reg", {24'd0, err_cnt}, exp_errs);
`endif

    // Read with a stalled consumer for 10 cycles.
    do_cmd(1'b0, 5'd5, 32'h0, 10, 1'b0);

    // Randomized traffic against the shadow model.
    for (int k = 0; k < 40; k++) begin
      do_cmd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset landing in the WRITE cycle: write commits, response dropped.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 5'd9;
    cmd_wdata = 32'h55;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("rst_in_write_wen", {31'd0, rf_wen}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b0;
    shadow[9] = 32'h55;
    exp_errs = 0;
    check_reset_outputs("rst_in_write");
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_write_no_rsp", {31'd0, rsp_valid}, 32'd0);
    do_cmd(1'b0, 5'd9, 32'h0, 0, 1'b0);

`ifdef RF_PORT_DRIVER_VERIFY_EN
    // Corrupted readbacks drive the saturating mismatch counter.
    check("err_cnt_after_rst", {24'd0, err_cnt}, 32'd0);
    do_cmd(1'b1, 5'd7, 32'h12, 0, 1'b1);
    check("err_cnt_first", {24'd0, err_cnt}, 32'd1);
    for (int k = 1; k < 300; k++) begin
      do_cmd(1'b1, 5'd7, 32'h12, 0, 1'b1);
    end
    check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
    check("err_cnt_model", exp_errs, 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
